// File: rtl/tl_pkg.sv
// tl_pkg: TileLink opcodes, size limit and responder FSM encoding
package tl_pkg;
    localparam logic [2:0] PUT_FULL        = 3'd0;
    localparam logic [2:0] PUT_PARTIAL     = 3'd1;
    localparam logic [2:0] ARITH           = 3'd2;
    localparam logic [2:0] LOGICAL         = 3'd3;
    localparam logic [2:0] GET             = 3'd4;
    localparam logic [2:0] INTENT          = 3'd5;
    localparam logic [2:0] ACCESS_ACK      = 3'd0;
    localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;
    localparam logic [2:0] HINT_ACK        = 3'd2;
    localparam logic [2:0] MAX_SIZE        = 3'd6;

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_ACK} state_e;

    // Index of the final beat; oversized requests collapse to a single beat
    function automatic logic [2:0] last_beat(input logic [2:0] size);
        return (size > 3'd3 && size <= MAX_SIZE) ? 3'((4'd1 << (size - 3'd3)) - 4'd1) : 3'd0;
    endfunction
endpackage

// File: rtl/tl_mem_array.sv
// tl_mem_array: 64-bit word RAM, async read, byte-masked sync write, optional index preload
module tl_mem_array #(
    parameter int MEM_WORDS  = 1024,
    parameter bit INIT_INDEX = 1'b1,
    localparam int AW        = $clog2(MEM_WORDS)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [63:0]   wdata_i,
    input  logic [7:0]    wmask_i,
    input  logic [AW-1:0] raddr_i,
    output logic [63:0]   rdata_o
);
    // Words are stored XORed with their preload value so a plain zero start
    // yields word i == i without a reset or load sequence.
    logic [63:0] raw_q [MEM_WORDS] = '{default: '0};
    logic [63:0] wbase, rbase;

    assign wbase   = INIT_INDEX ? 64'(waddr_i) : 64'd0;
    assign rbase   = INIT_INDEX ? 64'(raddr_i) : 64'd0;
    assign rdata_o = raw_q[raddr_i] ^ rbase;

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int b = 0; b < 8; b++) begin
                if (wmask_i[b]) raw_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8] ^ wbase[8*b +: 8];
            end
        end
    end
endmodule

// File: rtl/tl_mem_responder.sv
// tl_mem_responder: TileLink-UL/UH memory slave, one transaction in flight, RAM-backed
module tl_mem_responder
    import tl_pkg::*;
#(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int SRC_W      = 4,
    parameter int MEM_WORDS  = 1024,
    parameter bit INIT_INDEX = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        a_opcode,
    input  logic [2:0]        a_param,
    input  logic [2:0]        a_size,
    input  logic [SRC_W-1:0]  a_source,
    input  logic [ADDR_W-1:0] a_address,
    input  logic [7:0]        a_mask,
    input  logic [DATA_W-1:0] a_data,
    input  logic              a_valid,
    output logic              a_ready,
    output logic [2:0]        d_opcode,
    output logic [1:0]        d_param,
    output logic [2:0]        d_size,
    output logic [SRC_W-1:0]  d_source,
    output logic [1:0]        d_sink,
    output logic              d_denied,
    output logic              d_corrupt,
    output logic [DATA_W-1:0] d_data,
    output logic              d_valid,
    input  logic              d_ready
);
    localparam int IW = $clog2(MEM_WORDS);

    state_e           state_q;
    logic [2:0]       beat_q, last_q, opc_q, size_q;
    logic [IW-1:0]    idx_q;
    logic [SRC_W-1:0] src_q;
    logic             deny_q, corrupt_q;
    logic [ADDR_W:0]  a_end;
    logic [IW-1:0]    a_idx, cur_idx, waddr;
    logic [2:0]       a_last;
    logic [63:0]      rdata;
    logic             a_mis, a_deny, a_put, we;
    logic             unused_ok;

    assign unused_ok = ^a_param;
    assign a_idx     = a_address[IW+2:3];
    assign a_last    = last_beat(a_size);
    assign a_end     = {1'b0, a_address} + ((ADDR_W+1)'(1) << a_size);
    assign a_mis     = |(a_address[6:0] & ~(7'h7f << a_size));
    assign a_deny    = a_size > MAX_SIZE || a_mis || a_end > (ADDR_W+1)'(MEM_WORDS * 8) ||
                       a_opcode inside {ARITH, LOGICAL, 3'd6, 3'd7};
    assign a_put     = a_opcode == PUT_FULL || a_opcode == PUT_PARTIAL;
    assign cur_idx   = idx_q + IW'(beat_q);
    assign we        = a_valid & (state_q == S_IDLE ? a_put & ~a_deny : state_q == S_WR & ~deny_q);
    assign waddr     = state_q == S_IDLE ? a_idx : cur_idx;

    assign a_ready   = state_q == S_IDLE || state_q == S_WR;
    assign d_valid   = state_q == S_RD || state_q == S_ACK;
    assign d_opcode  = opc_q;
    assign d_param   = 2'd0;
    assign d_size    = size_q;
    assign d_source  = src_q;
    assign d_sink    = 2'd0;
    assign d_denied  = deny_q;
    assign d_corrupt = corrupt_q;
    assign d_data    = (state_q == S_RD && !deny_q) ? rdata : '0;

    tl_mem_array #(
        .MEM_WORDS  (MEM_WORDS),
        .INIT_INDEX (INIT_INDEX)
    ) u_mem (
        .clk     (clk),
        .we_i    (we),
        .waddr_i (waddr),
        .wdata_i (a_data),
        .wmask_i (a_mask),
        .raddr_i (cur_idx),
        .rdata_o (rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            beat_q    <= '0;
            last_q    <= '0;
            idx_q     <= '0;
            opc_q     <= '0;
            size_q    <= '0;
            src_q     <= '0;
            deny_q    <= 1'b0;
            corrupt_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (a_valid) begin
                    idx_q     <= a_idx;
                    last_q    <= a_last;
                    size_q    <= a_size;
                    src_q     <= a_source;
                    deny_q    <= a_deny;
                    corrupt_q <= 1'b0;
                    beat_q    <= '0;
                    if (a_opcode == GET) begin
                        state_q   <= S_RD;
                        opc_q     <= ACCESS_ACK_DATA;
                        corrupt_q <= a_deny;
                    end else if (a_opcode == INTENT) begin
                        state_q <= S_ACK;
                        opc_q   <= HINT_ACK;
                    end else if (a_opcode[2:1] == 2'b11) begin
                        state_q <= S_ACK;
                        opc_q   <= ACCESS_ACK;
                    end else begin
                        // Beat 0 is written on this fire, so WR resumes at beat 1
                        state_q <= a_last != 3'd0 ? S_WR : S_ACK;
                        opc_q   <= ACCESS_ACK;
                        beat_q  <= 3'(a_last != 3'd0);
                    end
                end
                S_RD: if (d_ready) begin
                    state_q <= beat_q == last_q ? S_IDLE : S_RD;
                    beat_q  <= beat_q == last_q ? 3'd0 : beat_q + 3'd1;
                end
                S_WR: if (a_valid) begin
                    state_q <= beat_q == last_q ? S_ACK : S_WR;
                    beat_q  <= beat_q == last_q ? 3'd0 : beat_q + 3'd1;
                end
                S_ACK: if (d_ready) state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tl_mem_responder.sv
// tb_tl_mem_responder: directed TileLink requests with a queued D-channel scoreboard
module tb_tl_mem_responder;
    typedef struct packed {
        logic [2:0]  op;
        logic [2:0]  size;
        logic [3:0]  src;
        logic        den;
        logic        cor;
        logic [63:0] data;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  a_opcode = '0, a_param = '0, a_size = '0;
    logic [3:0]  a_source = '0;
    logic [63:0] a_address = '0;
    logic [7:0]  a_mask = '0;
    logic [63:0] a_data = '0;
    logic        a_valid = 1'b0;
    logic        a_ready;
    logic [2:0]  d_opcode, d_size;
    logic [1:0]  d_param, d_sink;
    logic [3:0]  d_source;
    logic        d_denied, d_corrupt, d_valid;
    logic [63:0] d_data;
    logic        d_ready;

    int    errors = 0;
    int    checks = 0;
    beat_t exp_q[$];
    beat_t act, prev_act, mon_e;
    bit    prev_stall = 1'b0;
    bit    stall_mode = 1'b0;
    logic [0:3] pat = 4'b1001;
    int    ph = 0;

    assign act = {d_opcode, d_size, d_source, d_denied, d_corrupt, d_data};

    tl_mem_responder #(
        .ADDR_W(64), .DATA_W(64), .SRC_W(4), .MEM_WORDS(1024), .INIT_INDEX(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .a_opcode(a_opcode), .a_param(a_param), .a_size(a_size), .a_source(a_source),
        .a_address(a_address), .a_mask(a_mask), .a_data(a_data),
        .a_valid(a_valid), .a_ready(a_ready),
        .d_opcode(d_opcode), .d_param(d_param), .d_size(d_size), .d_source(d_source),
        .d_sink(d_sink), .d_denied(d_denied), .d_corrupt(d_corrupt),
        .d_data(d_data), .d_valid(d_valid), .d_ready(d_ready)
    );

    always #5 clk = ~clk;

    initial begin
        d_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            d_ready = stall_mode ? pat[ph] : 1'b1;
            ph = stall_mode ? (ph + 1) % 4 : 0;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) prev_stall = 1'b0;
        else begin
            if (prev_stall) begin
                checks++;
                if (!d_valid || act !== prev_act) begin
                    errors++;
                    $display("FAIL stall_hold: got valid=%b fields=%h, required valid=1 fields=%h", d_valid, act, prev_act);
                end
            end
            if (d_valid && d_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat: got fields=%h, required no beat", act);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (act !== mon_e || d_param !== 2'd0 || d_sink !== 2'd0) begin
                        errors++;
                        $display("FAIL d_beat: got fields=%h param=%0d sink=%0d, required fields=%h param=0 sink=0", act, d_param, d_sink, mon_e);
                    end
                end
            end
            prev_stall = d_valid && !d_ready;
            prev_act   = act;
        end
    end

    task automatic check(input string name, input logic [79:0] got, input logic [79:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    task automatic push(input logic [2:0] op, input logic [2:0] size, input logic [3:0] src,
                        input logic den, input logic cor, input logic [63:0] data);
        exp_q.push_back({op, size, src, den, cor, data});
    endtask

    task automatic push_run(input logic [2:0] op, input logic [2:0] size, input logic [3:0] src,
                            input logic den, input logic cor, input logic [63:0] d0, input int n, input int inc);
        for (int k = 0; k < n; k++) push(op, size, src, den, cor, d0 + 64'(inc * k));
    endtask

    task automatic send_a(input logic [2:0] op, input logic [2:0] size, input logic [3:0] src,
                          input logic [63:0] addr, input logic [7:0] mask, input logic [63:0] data, input logic exp_dv);
        int n = 0;
        a_opcode = op; a_size = size; a_source = src; a_address = addr; a_mask = mask; a_data = data;
        a_valid = 1'b1;
        while (!a_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("a_ready_wait", a_ready, 1);
        @(posedge clk);
        #1 a_valid = 1'b0;
        @(negedge clk);
        check("d_valid_next_cycle", d_valid, exp_dv);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || d_valid) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", 80'(exp_q.size()), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, required finish before 500000");
        $fatal(1);
    end

    initial begin
        #12;
        check("reset_d_valid", d_valid, 0);
        check("reset_d_fields", act, 0);
        check("reset_a_ready", a_ready, 1);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("idle_a_ready", a_ready, 1);

        push_run(3'd1, 3'd6, 4'd3, 1'b0, 1'b0, 64'h20, 8, 1);
        send_a(3'd4, 3'd6, 4'd3, 64'h100, 8'hff, 64'h0, 1'b1);
        drain();

        stall_mode = 1'b1;
        push_run(3'd1, 3'd6, 4'd3, 1'b0, 1'b0, 64'h20, 8, 1);
        send_a(3'd4, 3'd6, 4'd3, 64'h100, 8'hff, 64'h0, 1'b1);
        for (int n = 0; n < 100 && d_valid; n++) begin
            check("a_ready_busy", a_ready, 0);
            @(negedge clk);
        end
        check("a_ready_after_last", a_ready, 1);
        stall_mode = 1'b0;
        drain();

        push(3'd0, 3'd3, 4'd1, 1'b0, 1'b0, 64'h0);
        send_a(3'd0, 3'd3, 4'd1, 64'h100, 8'hff, 64'hDEADBEEF, 1'b1);
        drain();
        push(3'd1, 3'd3, 4'd2, 1'b0, 1'b0, 64'h00000000DEADBEEF);
        send_a(3'd4, 3'd3, 4'd2, 64'h100, 8'hff, 64'h0, 1'b1);
        drain();

        push(3'd0, 3'd3, 4'd1, 1'b0, 1'b0, 64'h0);
        send_a(3'd1, 3'd3, 4'd1, 64'h108, 8'h0f, 64'hAAAAAAAA55555555, 1'b1);
        drain();
        push(3'd1, 3'd3, 4'd1, 1'b0, 1'b0, 64'h0000000055555555);
        send_a(3'd4, 3'd3, 4'd1, 64'h108, 8'hff, 64'h0, 1'b1);
        drain();

        push(3'd0, 3'd4, 4'd6, 1'b0, 1'b0, 64'h0);
        send_a(3'd0, 3'd4, 4'd6, 64'h200, 8'hff, 64'h1111, 1'b0);
        send_a(3'd0, 3'd4, 4'd6, 64'h200, 8'hf0, 64'h123456789ABCDEF0, 1'b1);
        drain();
        push(3'd1, 3'd4, 4'd6, 1'b0, 1'b0, 64'h1111);
        push(3'd1, 3'd4, 4'd6, 1'b0, 1'b0, 64'h1234567800000041);
        send_a(3'd4, 3'd4, 4'd6, 64'h200, 8'hff, 64'h0, 1'b1);
        drain();

        push_run(3'd1, 3'd6, 4'd7, 1'b0, 1'b0, 64'h3f8, 8, 1);
        send_a(3'd4, 3'd6, 4'd7, 64'h1fc0, 8'hff, 64'h0, 1'b1);
        drain();

        push(3'd1, 3'd3, 4'd5, 1'b1, 1'b1, 64'h0);
        send_a(3'd4, 3'd3, 4'd5, 64'h2000, 8'hff, 64'h0, 1'b1);
        drain();
        push_run(3'd1, 3'd6, 4'd9, 1'b1, 1'b1, 64'h0, 8, 0);
        send_a(3'd4, 3'd6, 4'd9, 64'h108, 8'hff, 64'h0, 1'b1);
        drain();

        push(3'd0, 3'd3, 4'd2, 1'b1, 1'b0, 64'h0);
        send_a(3'd2, 3'd3, 4'd2, 64'h180, 8'hff, 64'hFFFFFFFFFFFFFFFF, 1'b1);
        drain();
        push(3'd1, 3'd3, 4'd2, 1'b0, 1'b0, 64'h30);
        send_a(3'd4, 3'd3, 4'd2, 64'h180, 8'hff, 64'h0, 1'b1);
        drain();

        push(3'd0, 3'd3, 4'd4, 1'b1, 1'b0, 64'h0);
        send_a(3'd7, 3'd3, 4'd4, 64'h0, 8'hff, 64'h0, 1'b1);
        drain();
        push(3'd2, 3'd6, 4'd8, 1'b0, 1'b0, 64'h0);
        send_a(3'd5, 3'd6, 4'd8, 64'h40, 8'hff, 64'h0, 1'b1);
        drain();

        push(3'd0, 3'd4, 4'd10, 1'b1, 1'b0, 64'h0);
        send_a(3'd0, 3'd4, 4'd10, 64'h108, 8'hff, 64'hBAD, 1'b0);
        send_a(3'd0, 3'd4, 4'd10, 64'h108, 8'hff, 64'hBAD, 1'b1);
        drain();
        push(3'd1, 3'd3, 4'd10, 1'b0, 1'b0, 64'h0000000055555555);
        send_a(3'd4, 3'd3, 4'd10, 64'h108, 8'hff, 64'h0, 1'b1);
        drain();

        push_run(3'd1, 3'd6, 4'd12, 1'b0, 1'b0, 64'h0, 8, 1);
        send_a(3'd4, 3'd6, 4'd12, 64'h0, 8'hff, 64'h0, 1'b1);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midburst_reset_d_valid", d_valid, 0);
        check("midburst_reset_fields", act, 0);
        check("midburst_reset_a_ready", a_ready, 1);
        exp_q.delete();
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        push(3'd1, 3'd3, 4'd13, 1'b0, 1'b0, 64'h0);
        send_a(3'd4, 3'd3, 4'd13, 64'h0, 8'hff, 64'h0, 1'b1);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/tl_mem_responder.md
# tl_mem_responder

TileLink-UL/UH memory slave that terminates the cache system's memory port (L2 → memory A channel, memory → L2 D channel). It accepts Get, PutFullData, PutPartialData and Intent requests on channel A. It answers with single- or multi-beat AccessAckData, AccessAck or HintAck on channel D, backed by an internal word-addressed RAM. It is the synthesizable replacement for ad-hoc bench memory models, with one transaction outstanding at a time.

## Interface
- ADDR_W, 64, address width
- DATA_W, 64, beat width; fixed at 64 (8 byte lanes)
- SRC_W, 4, source ID width
- MEM_WORDS, 1024, RAM depth in 64-bit words; power of two (8 KB at default)
- INIT_INDEX, 1, 1: word i initialised to i at time zero; 0: all zero
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- a_opcode/a_param/a_size  in  3/3/3  A opcode, param (ignored), log2 bytes
- a_source  in  SRC_W  requester ID
- a_address  in  ADDR_W  byte address
- a_mask  in  8  byte-lane enables
- a_data  in  64  write data
- a_valid  in  1; a_ready  out  1
- d_opcode  out  3; d_param  out  2 (always 0); d_size  out  3; d_source  out  SRC_W; d_sink  out  2 (always 0)
- d_denied, d_corrupt  out  1 each
- d_data  out  64; d_valid  out  1; d_ready  in  1

## Operation
- States: IDLE, RD (issuing data beats), WR (collecting Put beats), ACK (single-beat response pending).
- Beats = 1 for a_size ≤ 3, else 2^(a_size−3). Legal a_size is 0..6 (max 8 beats).
- A request is denied if any of these holds:
  - a_size > 6
  - the address is not aligned to 2^a_size
  - address + 2^a_size > MEM_WORDS×8
  - opcode is 2, 3, 6 or 7
- Word index for beat k = a_address[log2(MEM_WORDS)+2:3] + k. No wrap is possible for a legal request.
- On A fire in IDLE, latch source, size, word index and beat count. Then:
  - Get (4): go to RD; d_opcode=1 (AccessAckData).
  - PutFullData (0) or PutPartialData (1): write beat 0 into RAM under a_mask. Go to WR if beats > 1, else ACK; d_opcode=0.
  - Intent (5): go to ACK; d_opcode=2 (HintAck).
  - Denied Get: RD, all beats with d_denied=1, d_corrupt=1, d_data=0, no RAM read.
  - Denied opcode 0, 1, 2, 3: consume all beats in WR without writing, then ACK with d_denied=1 (d_corrupt=0).
  - Denied opcode 6, 7: go to ACK, d_opcode=0, d_denied=1.
- RD: d_data = RAM[index + beat counter]. Each D fire increments the counter; the last fire returns to IDLE.
- WR: each A fire writes under a_mask and increments the counter; the last fire goes to ACK.
- ACK: one D beat; fire returns to IDLE.
- PutFullData with a non-all-ones mask is still written under the mask.
- Memory contents are not touched by reset; a reset mid-Put leaves already-written beats in RAM.

## Timing
- Reset values: a_ready=1, d_valid=0, d_opcode=0, d_size=0, d_source=0, d_denied=0, d_corrupt=0, d_data=0, state IDLE, beat counter 0.
- a_ready = (state==IDLE) | (state==WR), combinational from state. Responses never combinationally depend on a_valid.
- Get accepted at cycle T: beat 0 is valid at T+1. With d_ready held high, beat k is valid at T+1+k.
- Single-beat Put or Intent accepted at T: response valid at T+1. Multi-beat Put: response at L+1, where L is the last A beat cycle.
- d_valid holds high until fire. All D fields stay stable while d_valid=1 and d_ready=0.
- After the last D fire at cycle F, the FSM is in IDLE and a_ready=1 at F+1. No request is accepted at F itself.
- Reset asserted mid-burst: all outputs take their reset values immediately (asynchronously). After release the FSM starts in IDLE.

## Structure
- Shared package tl_pkg holds:
  - A opcode constants: PUT_FULL=0, PUT_PARTIAL=1, ARITH=2, LOGICAL=3, GET=4, INTENT=5
  - D opcode constants: ACCESS_ACK=0, ACCESS_ACK_DATA=1, HINT_ACK=2
  - MAX_SIZE=6
  - the FSM state encoding
- One sub-module, tl_mem_array: MEM_WORDS×64 storage, asynchronous read port, synchronous write port with byte mask, INIT_INDEX initialisation.

## Test plan
- Get 0x100 size 6 source 3, d_ready=1 → 8 beats with data 0x20..0x27; d_opcode=1, d_size=6, d_source=3, d_denied=0; beat 0 arrives one cycle after A fire.
- PutFullData 0x100 size 3, data 0xDEADBEEF, mask 0xFF → AccessAck one cycle later; then Get 0x100 size 3 → 0x00000000DEADBEEF.
- PutPartialData 0x108 size 3, mask 0x0F, data 0xAAAAAAAA55555555 → AccessAck; then Get 0x108 → 0x0000000055555555.
- 8-beat Get with d_ready toggling 1,0,0,1,… → d_data stable during stalls, beats in order 0x20..0x27, a_ready=0 until one cycle after the last fire.
- Get 0x2000 size 3 → one beat with d_denied=1, d_corrupt=1, d_data=0. Get 0x108 size 6 (misaligned) → 8 denied beats. Opcode 2 size 3 → AccessAck with d_denied=1 and RAM unchanged.
- Reset asserted after the 3rd D beat of a Get → d_valid=0 immediately and a_ready=1 after release; a following Get 0x000 size 3 returns 0x0.
